// File: rtl/axi_capture_pkg.sv
// Shared field widths, capture-word sizing and default-layout channel offsets
// for the AXI4 capture snoop and anything that decodes its output word.
package axi_capture_pkg;

    localparam int ID_WIDTH_DEF    = 4;
    localparam int ADDR_WIDTH_DEF  = 64;
    localparam int DATA_WIDTH_DEF  = 64;
    localparam int USER_WIDTH_DEF  = 1;
    localparam int STAMP_WIDTH_DEF = 14;

    // Fixed-width bits per channel, excluding id/addr/data/strb/user.
    // AW/AR: len 8 + size 3 + burst 2 + lock 1 + cache 4 + prot 3 + region 4 + qos 4 + valid + ready.
    localparam int AX_FIXED_BITS = 31;
    localparam int W_FIXED_BITS  = 3;   // last, valid, ready
    localparam int B_FIXED_BITS  = 4;   // resp 2, valid, ready
    localparam int R_FIXED_BITS  = 5;   // resp 2, last, valid, ready
    localparam int FIRE_BITS     = 5;

    function automatic int capture_width(input int id_w, input int addr_w, input int data_w,
                                         input int user_w, input int stamp_w);
        return stamp_w + FIRE_BITS
             + 2 * (id_w + addr_w + user_w + AX_FIXED_BITS)
             + (data_w + data_w / 8 + user_w + W_FIXED_BITS)
             + (id_w + user_w + B_FIXED_BITS)
             + (id_w + data_w + user_w + R_FIXED_BITS);
    endfunction

    localparam int AX_BITS_DEF = ID_WIDTH_DEF + ADDR_WIDTH_DEF + USER_WIDTH_DEF + AX_FIXED_BITS;

    // Channel LSB positions inside the word at the default parameterisation.
    localparam int R_LSB     = 0;
    localparam int AR_LSB    = R_LSB + ID_WIDTH_DEF + DATA_WIDTH_DEF + USER_WIDTH_DEF + R_FIXED_BITS;
    localparam int B_LSB     = AR_LSB + AX_BITS_DEF;
    localparam int W_LSB     = B_LSB + ID_WIDTH_DEF + USER_WIDTH_DEF + B_FIXED_BITS;
    localparam int AW_LSB    = W_LSB + DATA_WIDTH_DEF + DATA_WIDTH_DEF / 8 + USER_WIDTH_DEF + W_FIXED_BITS;
    localparam int FIRE_LSB  = AW_LSB + AX_BITS_DEF;
    localparam int STAMP_LSB = FIRE_LSB + FIRE_BITS;

endpackage

// File: rtl/axi_capture_stamp.sv
// Free-running wrapping cycle-stamp counter with synchronous active-high reset.
module axi_capture_stamp #(
    parameter int STAMP_WIDTH = 14
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [STAMP_WIDTH-1:0] stamp_o
);

    logic [STAMP_WIDTH-1:0] count_q, count_d;

    // Natural overflow gives the wrap to zero.
    always_comb begin
        count_d = count_q + STAMP_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stamp_o = count_q;

endmodule

// File: rtl/axi_capture_snoop.sv
// Passive registered snapshot of one AXI4 bus: all five channels, handshake
// flags and a cycle stamp packed into one flat word per clock.
module axi_capture_snoop
    import axi_capture_pkg::*;
#(
    parameter int   ID_WIDTH      = ID_WIDTH_DEF,
    parameter int   ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int   DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int   USER_WIDTH    = USER_WIDTH_DEF,
    parameter int   STAMP_WIDTH   = STAMP_WIDTH_DEF,
    localparam int  CAPTURE_WIDTH = capture_width(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH, STAMP_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      capture_en_i,

    input  logic [ID_WIDTH-1:0]       aw_id,
    input  logic [ADDR_WIDTH-1:0]     aw_addr,
    input  logic [7:0]                aw_len,
    input  logic [2:0]                aw_size,
    input  logic [1:0]                aw_burst,
    input  logic                      aw_lock,
    input  logic [3:0]                aw_cache,
    input  logic [2:0]                aw_prot,
    input  logic [3:0]                aw_region,
    input  logic [3:0]                aw_qos,
    input  logic [USER_WIDTH-1:0]     aw_user,
    input  logic                      aw_valid,
    input  logic                      aw_ready,

    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic [DATA_WIDTH/8-1:0]   w_strb,
    input  logic                      w_last,
    input  logic [USER_WIDTH-1:0]     w_user,
    input  logic                      w_valid,
    input  logic                      w_ready,

    input  logic [ID_WIDTH-1:0]       b_id,
    input  logic [1:0]                b_resp,
    input  logic [USER_WIDTH-1:0]     b_user,
    input  logic                      b_valid,
    input  logic                      b_ready,

    input  logic [ID_WIDTH-1:0]       ar_id,
    input  logic [ADDR_WIDTH-1:0]     ar_addr,
    input  logic [7:0]                ar_len,
    input  logic [2:0]                ar_size,
    input  logic [1:0]                ar_burst,
    input  logic                      ar_lock,
    input  logic [3:0]                ar_cache,
    input  logic [2:0]                ar_prot,
    input  logic [3:0]                ar_region,
    input  logic [3:0]                ar_qos,
    input  logic [USER_WIDTH-1:0]     ar_user,
    input  logic                      ar_valid,
    input  logic                      ar_ready,

    input  logic [ID_WIDTH-1:0]       r_id,
    input  logic [DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                r_resp,
    input  logic                      r_last,
    input  logic [USER_WIDTH-1:0]     r_user,
    input  logic                      r_valid,
    input  logic                      r_ready,

    output logic [CAPTURE_WIDTH-1:0]  capture_o
);

    logic [STAMP_WIDTH-1:0]   stamp;
    logic [4:0]               fire;
    logic [CAPTURE_WIDTH-1:0] capture_q, capture_d;

    // The stamp keeps counting while capture is disabled, so gaps in a trace are visible.
    axi_capture_stamp #(
        .STAMP_WIDTH (STAMP_WIDTH)
    ) u_stamp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stamp_o (stamp)
    );

    always_comb begin
        fire = {aw_valid & aw_ready, w_valid & w_ready, b_valid & b_ready,
                ar_valid & ar_ready, r_valid & r_ready};
        capture_d = capture_q;
        if (capture_en_i) begin
            capture_d = {stamp, fire,
                         aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
                         aw_prot, aw_region, aw_qos, aw_user, aw_valid, aw_ready,
                         w_data, w_strb, w_last, w_user, w_valid, w_ready,
                         b_id, b_resp, b_user, b_valid, b_ready,
                         ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
                         ar_prot, ar_region, ar_qos, ar_user, ar_valid, ar_ready,
                         r_id, r_data, r_resp, r_last, r_user, r_valid, r_ready};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            capture_q <= '0;
        end else begin
            capture_q <= capture_d;
        end
    end

    assign capture_o = capture_q;

endmodule

// File: tb/tb_axi_capture_snoop.sv
// Randomised bench for axi_capture_snoop against a field-placement model of the capture word.
module tb_axi_capture_snoop;
    import axi_capture_pkg::*;

    localparam int CW        = capture_width(ID_WIDTH_DEF, ADDR_WIDTH_DEF, DATA_WIDTH_DEF,
                                             USER_WIDTH_DEF, STAMP_WIDTH_DEF);
    localparam int SW        = STAMP_WIDTH_DEF;
    localparam int STAMP_MOD = 1 << SW;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic capture_en_i = 1'b0;

    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [63:0] aw_addr, ar_addr, w_data, r_data;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic        aw_lock, ar_lock;
    logic [3:0]  aw_cache, ar_cache, aw_region, ar_region, aw_qos, ar_qos;
    logic        aw_user, ar_user, w_user, b_user, r_user;
    logic        aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready;
    logic        b_valid, b_ready, r_valid, r_ready, w_last, r_last;
    logic [CW-1:0] capture_o;

    int checks = 0;
    int failures = 0;
    logic [CW-1:0] exp_word = '0;
    int m_stamp = 0;

    always #5 clk = ~clk;

    axi_capture_snoop dut (
        .clk_i(clk), .rst_i(rst_i), .capture_en_i(capture_en_i),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_region(aw_region),
        .aw_qos(aw_qos), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_region(ar_region),
        .ar_qos(ar_qos), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
        .r_valid(r_valid), .r_ready(r_ready),
        .capture_o(capture_o)
    );

    // Model: fields are laid down bit by bit from the LSB upward with a cursor.
    task automatic ins(inout logic [CW-1:0] w, inout int p, input logic [63:0] v, input int wd);
        for (int i = 0; i < wd; i++) w[p + i] = v[i];
        p += wd;
    endtask

    task automatic build_expected(input int stamp, output logic [CW-1:0] w);
        int p;
        w = '0;
        p = 0;
        ins(w, p, 64'(r_ready), 1);  ins(w, p, 64'(r_valid), 1);  ins(w, p, 64'(r_user), 1);
        ins(w, p, 64'(r_last), 1);   ins(w, p, 64'(r_resp), 2);   ins(w, p, r_data, 64);
        ins(w, p, 64'(r_id), 4);
        ins(w, p, 64'(ar_ready), 1); ins(w, p, 64'(ar_valid), 1); ins(w, p, 64'(ar_user), 1);
        ins(w, p, 64'(ar_qos), 4);   ins(w, p, 64'(ar_region), 4); ins(w, p, 64'(ar_prot), 3);
        ins(w, p, 64'(ar_cache), 4); ins(w, p, 64'(ar_lock), 1);  ins(w, p, 64'(ar_burst), 2);
        ins(w, p, 64'(ar_size), 3);  ins(w, p, 64'(ar_len), 8);   ins(w, p, ar_addr, 64);
        ins(w, p, 64'(ar_id), 4);
        ins(w, p, 64'(b_ready), 1);  ins(w, p, 64'(b_valid), 1);  ins(w, p, 64'(b_user), 1);
        ins(w, p, 64'(b_resp), 2);   ins(w, p, 64'(b_id), 4);
        ins(w, p, 64'(w_ready), 1);  ins(w, p, 64'(w_valid), 1);  ins(w, p, 64'(w_user), 1);
        ins(w, p, 64'(w_last), 1);   ins(w, p, 64'(w_strb), 8);   ins(w, p, w_data, 64);
        ins(w, p, 64'(aw_ready), 1); ins(w, p, 64'(aw_valid), 1); ins(w, p, 64'(aw_user), 1);
        ins(w, p, 64'(aw_qos), 4);   ins(w, p, 64'(aw_region), 4); ins(w, p, 64'(aw_prot), 3);
        ins(w, p, 64'(aw_cache), 4); ins(w, p, 64'(aw_lock), 1);  ins(w, p, 64'(aw_burst), 2);
        ins(w, p, 64'(aw_size), 3);  ins(w, p, 64'(aw_len), 8);   ins(w, p, aw_addr, 64);
        ins(w, p, 64'(aw_id), 4);
        ins(w, p, 64'(r_valid & r_ready), 1);   ins(w, p, 64'(ar_valid & ar_ready), 1);
        ins(w, p, 64'(b_valid & b_ready), 1);   ins(w, p, 64'(w_valid & w_ready), 1);
        ins(w, p, 64'(aw_valid & aw_ready), 1);
        ins(w, p, 64'(stamp), SW);
    endtask

    // One clock: the model reacts to what was driven before the edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst_i) begin
            exp_word = '0;
            m_stamp = 0;
        end else begin
            if (capture_en_i) build_expected(m_stamp, exp_word);
            m_stamp = (m_stamp + 1) % STAMP_MOD;
        end
        #1;
    endtask

    task automatic set_all(input logic v);
        {aw_id, ar_id, b_id, r_id} = {16{v}};
        {aw_addr, ar_addr, w_data, r_data} = {256{v}};
        {aw_len, ar_len, w_strb} = {24{v}};
        {aw_size, ar_size, aw_prot, ar_prot} = {12{v}};
        {aw_burst, ar_burst, b_resp, r_resp} = {8{v}};
        {aw_lock, ar_lock, aw_user, ar_user, w_user, b_user, r_user} = {7{v}};
        {aw_cache, ar_cache, aw_region, ar_region, aw_qos, ar_qos} = {24{v}};
        {aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready} = {6{v}};
        {b_valid, b_ready, r_valid, r_ready, w_last, r_last} = {6{v}};
    endtask

    task automatic rand_inputs();
        aw_id = 4'($urandom); ar_id = 4'($urandom); b_id = 4'($urandom); r_id = 4'($urandom);
        aw_addr = {$urandom, $urandom}; ar_addr = {$urandom, $urandom};
        w_data = {$urandom, $urandom};  r_data = {$urandom, $urandom};
        aw_len = 8'($urandom); ar_len = 8'($urandom); w_strb = 8'($urandom);
        {aw_size, ar_size, aw_prot, ar_prot} = 12'($urandom);
        {aw_burst, ar_burst, b_resp, r_resp} = 8'($urandom);
        {aw_lock, ar_lock, aw_user, ar_user, w_user, b_user, r_user} = 7'($urandom);
        {aw_cache, ar_cache, aw_region, ar_region, aw_qos, ar_qos} = 24'($urandom);
        {aw_valid, aw_ready, ar_valid, ar_ready, w_valid, w_ready} = 6'($urandom);
        {b_valid, b_ready, r_valid, r_ready, w_last, r_last} = 6'($urandom);
    endtask

    task automatic test_reset();
        set_all(1'b1);
        capture_en_i = 1'b1;
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (capture_o !== '0) begin
                failures++;
                $display("FAIL reset_zero cycle=%0d got=%h want=0", i, capture_o);
            end
        end
        rst_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (capture_o[STAMP_LSB +: SW] !== SW'(k)) begin
                failures++;
                $display("FAIL reset_stamp k=%0d got=%0d want=%0d", k, capture_o[STAMP_LSB +: SW], k);
            end
            checks++;
            if (capture_o !== exp_word) begin
                failures++;
                $display("FAIL reset_word k=%0d got=%h want=%h", k, capture_o, exp_word);
            end
        end
    endtask

    task automatic test_aw_field();
        set_all(1'b0);
        aw_addr = 64'h0000_0000_8000_1000;
        aw_id = 4'h5;
        aw_len = 8'h0F;
        aw_valid = 1'b1;
        step();
        checks++;
        if (capture_o[358:355] !== 4'h5) begin
            failures++; $display("FAIL aw_id got=%h want=5", capture_o[358:355]);
        end
        checks++;
        if (capture_o[354:291] !== 64'h0000_0000_8000_1000) begin
            failures++; $display("FAIL aw_addr got=%h want=0000000080001000", capture_o[354:291]);
        end
        checks++;
        if (capture_o[290:283] !== 8'h0F) begin
            failures++; $display("FAIL aw_len got=%h want=0f", capture_o[290:283]);
        end
        checks++;
        if ({capture_o[363], capture_o[260], capture_o[259]} !== 3'b010) begin
            failures++;
            $display("FAIL aw_flags fire/valid/ready got=%b want=010",
                     {capture_o[363], capture_o[260], capture_o[259]});
        end
        checks++;
        if (capture_o !== exp_word) begin
            failures++; $display("FAIL aw_word got=%h want=%h", capture_o, exp_word);
        end
    endtask

    task automatic test_w_handshake();
        set_all(1'b0);
        w_valid = 1'b1;
        w_ready = 1'b1;
        w_data = 64'hDEAD_BEEF_0123_4567;
        w_strb = 8'hFF;
        w_last = 1'b1;
        step();
        checks++;
        if (capture_o[362] !== 1'b1) begin
            failures++; $display("FAIL w_fire got=%b want=1", capture_o[362]);
        end
        checks++;
        if (capture_o[258:195] !== 64'hDEAD_BEEF_0123_4567) begin
            failures++; $display("FAIL w_data got=%h want=deadbeef01234567", capture_o[258:195]);
        end
        checks++;
        if ({capture_o[194:187], capture_o[186], capture_o[184:183]} !== 11'b11111111_1_11) begin
            failures++;
            $display("FAIL w_strb_last_vr got=%b want=11111111111",
                     {capture_o[194:187], capture_o[186], capture_o[184:183]});
        end
        checks++;
        if (capture_o[361:359] !== 3'b000) begin
            failures++; $display("FAIL w_other_fire got=%b want=000", capture_o[361:359]);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            capture_en_i = ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (capture_o !== exp_word) begin
                failures++; $display("FAIL random i=%0d got=%h want=%h", i, capture_o, exp_word);
            end
        end
        capture_en_i = 1'b1;
    endtask

    task automatic test_hold();
        logic [CW-1:0] held;
        logic [SW-1:0] held_stamp;
        capture_en_i = 1'b1;
        rand_inputs();
        step();
        held = exp_word;
        held_stamp = exp_word[STAMP_LSB +: SW];
        capture_en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            r_data = {$urandom, $urandom};
            r_valid = ~r_valid;
            step();
            checks++;
            if (capture_o !== held) begin
                failures++; $display("FAIL hold i=%0d got=%h want=%h", i, capture_o, held);
            end
        end
        capture_en_i = 1'b1;
        step();
        checks++;
        if (capture_o[STAMP_LSB +: SW] !== SW'(held_stamp + 11)) begin
            failures++;
            $display("FAIL hold_resume_stamp got=%0d want=%0d", capture_o[STAMP_LSB +: SW], SW'(held_stamp + 11));
        end
        checks++;
        if (capture_o !== exp_word) begin
            failures++; $display("FAIL hold_resume_word got=%h want=%h", capture_o, exp_word);
        end
    endtask

    task automatic test_wrap();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        capture_en_i = 1'b1;
        for (int k = 0; k <= STAMP_MOD + 1; k++) begin
            if ((k % 512) == 0) rand_inputs();
            step();
            checks++;
            if (capture_o[STAMP_LSB +: SW] !== SW'(k % STAMP_MOD)) begin
                failures++;
                $display("FAIL wrap_stamp k=%0d got=%0d want=%0d", k, capture_o[STAMP_LSB +: SW], k % STAMP_MOD);
            end
        end
    endtask

    task automatic test_midrun_reset();
        capture_en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_inputs();
            step();
        end
        rand_inputs();
        rst_i = 1'b1;
        step();
        checks++;
        if (capture_o !== '0) begin
            failures++; $display("FAIL midrun_reset_zero got=%h want=0", capture_o);
        end
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            step();
            checks++;
            if (capture_o[STAMP_LSB +: SW] !== SW'(k)) begin
                failures++;
                $display("FAIL midrun_stamp k=%0d got=%0d want=%0d", k, capture_o[STAMP_LSB +: SW], k);
            end
            checks++;
            if (capture_o !== exp_word) begin
                failures++; $display("FAIL midrun_word k=%0d got=%h want=%h", k, capture_o, exp_word);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_all(1'b0);
        test_reset();
        test_aw_field();
        test_w_handshake();
        test_random(300);
        test_hold();
        test_wrap();
        test_midrun_reset();
        test_random(100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
